// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and deglitched line inputs, an 11-bit frame
// decoder, and a first-word-fall-through scancode FIFO with sticky error flags.
module ps2_rx_fifo #(
  parameter int DEPTH   = 8,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                         fclk,
  input  logic                         rst,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         rdn,
  input  logic                         err_clr,
  output logic [7:0]                   data_out,
  output logic                         data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2, rdn_s1, rdn_s2, rdn_d;
  logic          fc, fc_d;
  logic [FW-1:0] fcnt;
  logic          fe, rbit, rd_rise;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          ok;
  logic [TW-1:0] tcnt;
  logic          stop_fe, tout, push, pop, par_set, frm_set;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, do_push, ovf_set;

  // Idle-high lines reset to 1 so no false edge is seen as reset releases.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      rdn_s1 <= 1'b1;
      rdn_s2 <= 1'b1;
      rdn_d  <= 1'b1;
      fc     <= 1'b1;
      fc_d   <= 1'b1;
      fcnt   <= '0;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      rdn_s1 <= rdn;
      rdn_s2 <= rdn_s1;
      rdn_d  <= rdn_s2;
      fc_d   <= fc;
      if (clk_s2 == fc) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER - 1)) begin
        fc   <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fe      = fc_d & ~fc;
  assign rbit    = dat_s2;
  assign rd_rise = rdn_s2 & ~rdn_d;

  assign stop_fe = fe && (state == STOP);
  assign tout    = (state != IDLE) && !fe && (tcnt == TW'(TIMEOUT - 1));
  assign push    = stop_fe && rbit && ok;
  assign par_set = stop_fe && !ok;
  assign frm_set = (stop_fe && !rbit && ok) || tout;

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      bitcnt <= '0;
      shift  <= '0;
      ok     <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (state == IDLE || fe) tcnt <= '0;
      else if (!tout)          tcnt <= tcnt + 1'b1;

      if (tout) begin
        state <= IDLE;
      end else if (fe) begin
        case (state)
          IDLE: begin
            if (!rbit) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shift[bitcnt] <= rbit;
            if (bitcnt == 3'd7) state <= PARITY;
            else                bitcnt <= bitcnt + 1'b1;
          end
          PARITY: begin
            ok    <= (^shift) ^ rbit;
            state <= STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_rise && !empty;
  // A pop in the same cycle frees the slot the write pointer is aiming at.
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (par_set)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (frm_set)      frame_err  <= 1'b1;
      else if (err_clr) frame_err  <= 1'b0;
      if (ovf_set)      overflow   <= 1'b1;
      else if (err_clr) overflow   <= 1'b0;
    end
  end

  assign data_out   = mem[rd_ptr[AW-1:0]];
  assign data_ready = !empty;
  assign count      = CW'(wr_ptr - rd_ptr);

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins and every
// observable output is compared against hand-computed values.
module tb_ps2_rx_fifo;

  localparam int DEPTH   = 8;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;

  logic       fclk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rdn, err_clr;
  logic [7:0] data_out;
  logic       data_ready, parity_err, frame_err, overflow;
  logic [3:0] count;

  int n_cmp = 0;
  int n_err = 0;

  ps2_rx_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .fclk(fclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rdn(rdn),
    .err_clr(err_clr), .data_out(data_out), .data_ready(data_ready), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 fclk = ~fclk;

  task automatic tick(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      tick(5);
      ps2_clk = 1'b0;
      tick(FILTER - 1);
      ps2_clk = 1'b1;
      tick(HALF - 5 - (FILTER - 1));
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  // pop_at_stop lines the rdn rising edge up so the pop lands in the push cycle.
  task automatic send_frame(input logic [7:0] b, input logic par_inv,
                            input logic glitch, input logic pop_at_stop);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ par_inv, glitch);
    ps2_data = 1'b1;
    if (pop_at_stop) rdn = 1'b0;
    tick(HALF);
    ps2_clk = 1'b0;
    if (pop_at_stop) begin
      tick(FILTER);
      rdn = 1'b1;
      tick(HALF - FILTER);
    end else begin
      tick(HALF);
    end
    ps2_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic do_pop();
    rdn = 1'b0;
    tick(4);
    rdn = 1'b1;
    tick(5);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " data_out"},   32'(data_out),   32'h0);
    chk({tag, " data_ready"}, 32'(data_ready), 32'h0);
    chk({tag, " count"},      32'(count),      32'h0);
    chk({tag, " flags"},      32'({parity_err, frame_err, overflow}), 32'h0);
  endtask

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rdn = 1'b1; err_clr = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("1c ready", 32'(data_ready), 32'h1);
    chk("1c data",  32'(data_out),   32'h1C);
    chk("1c count", 32'(count),      32'h1);
    chk("1c flags", 32'({parity_err, frame_err, overflow}), 32'h0);
    do_pop();
    chk("1c pop ready", 32'(data_ready), 32'h0);
    chk("1c pop count", 32'(count),      32'h0);

    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("5a parity_err", 32'(parity_err), 32'h1);
    chk("5a frame_err",  32'(frame_err),  32'h0);
    chk("5a count",      32'(count),      32'h0);
    pulse_clr();
    chk("5a cleared", 32'(parity_err), 32'h0);

    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill count",    32'(count),    32'h8);
    chk("fill overflow", 32'(overflow), 32'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("fill read %0d", i), 32'(data_out), 32'(i));
      do_pop();
    end
    chk("fill drained", 32'(count), 32'h0);
    pulse_clr();
    chk("ovf cleared", 32'(overflow), 32'h0);

    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    chk("wrap count", 32'(count),    32'h8);
    chk("wrap ovf",   32'(overflow), 32'h0);
    chk("wrap head",  32'(data_out), 32'h11);

    send_frame(8'h77, 1'b0, 1'b0, 1'b1);
    chk("pp count", 32'(count),    32'h8);
    chk("pp ovf",   32'(overflow), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("pp read %0d", i),
          32'(data_out), (i == DEPTH - 1) ? 32'h77 : 32'(8'h12 + i));
      do_pop();
    end
    chk("pp drained", 32'(data_ready), 32'h0);

    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    chk("to before", 32'(frame_err), 32'h0);
    tick(TIMEOUT + 20);
    chk("to frame_err", 32'(frame_err), 32'h1);
    chk("to count",     32'(count),     32'h0);
    pulse_clr();
    chk("to cleared", 32'(frame_err), 32'h0);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    chk("29 data",  32'(data_out), 32'h29);
    chk("29 count", 32'(count),    32'h1);
    chk("29 flags", 32'({parity_err, frame_err, overflow}), 32'h0);
    do_pop();

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    chk("glitch data",  32'(data_out), 32'h3C);
    chk("glitch count", 32'(count),    32'h1);
    chk("glitch flags", 32'({parity_err, frame_err, overflow}), 32'h0);

    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    rst = 1'b0;
    tick(2);
    chk_all_zero("midrst low");
    rst = 1'b1;
    tick(HALF);
    chk_all_zero("midrst rel");
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);
    chk("16 data",  32'(data_out), 32'h16);
    chk("16 count", 32'(count),    32'h1);
    chk("16 flags", 32'({parity_err, frame_err, overflow}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
